// File: rtl/wenneb_pkg.sv
// Shared types and constants for the wenneb byte-serial transmit path.
package wenneb_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam int   DATA_BITS   = 8;
endpackage

// File: rtl/byte_fifo.sv
// Show-ahead byte FIFO; power-of-two DEPTH so the pointers wrap naturally.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_level;
  logic          w_push, w_pop;

  assign full   = (r_level == FULL_LVL);
  assign empty  = (r_level == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  assign dout  = r_mem[r_rptr];
  assign level = r_level;
endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serialiser (LSB first).
// Optional even-parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_fifo
  import wenneb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t  r_state, w_state_nx;
  logic [BW-1:0] r_baud, w_baud_nx;
  logic [2:0] r_bitcnt, w_bitcnt_nx;
  logic [7:0] r_shift, w_shift_nx;
  logic       r_tx, w_tx_nx;
  logic       r_busy, w_busy_nx;
  logic       w_push, w_pop, w_full, w_empty, w_bit_end;
  logic [7:0] w_dout;
`ifdef UART_TX_PARITY_EN
  logic       r_par, w_par_nx;
`endif

  assign wr_ready  = ena && !w_full;
  assign w_push    = wr_valid && wr_ready;
  assign w_bit_end = (r_baud == BAUD_MAX);

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (wr_data),
    .dout  (w_dout),
    .level (fifo_level),
    .full  (w_full),
    .empty (w_empty)
  );

  always_comb begin
    w_state_nx  = r_state;
    w_baud_nx   = r_baud + 1'b1;
    w_bitcnt_nx = r_bitcnt;
    w_shift_nx  = r_shift;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        w_baud_nx = '0;
        if (!w_empty && ena) begin
          w_pop      = 1'b1;
          w_shift_nx = w_dout;
          w_state_nx = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_baud_nx  = '0;
          w_state_nx = DATA;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_baud_nx  = '0;
          w_shift_nx = {1'b0, r_shift[7:1]};
          if (r_bitcnt == LAST_BIT) begin
            w_bitcnt_nx = '0;
`ifdef UART_TX_PARITY_EN
            w_state_nx  = PARITY;
`else
            w_state_nx  = STOP;
`endif
          end else begin
            w_bitcnt_nx = r_bitcnt + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          w_baud_nx  = '0;
          w_state_nx = STOP;
        end
      end
`endif
      STOP: begin
        if (w_bit_end) begin
          w_baud_nx = '0;
          // Chain straight into the next start bit when more data waits.
          if (!w_empty && ena) begin
            w_pop      = 1'b1;
            w_shift_nx = w_dout;
            w_state_nx = START;
          end else begin
            w_state_nx = IDLE;
          end
        end
      end
      default: begin
        w_baud_nx  = '0;
        w_state_nx = IDLE;
      end
    endcase
  end

`ifdef UART_TX_PARITY_EN
  assign w_par_nx = w_pop ? ^w_dout : r_par;
`endif

  // Line level is computed from the next state so tx itself is a flop.
  always_comb begin
    w_tx_nx = IDLE_LEVEL;
    case (w_state_nx)
      START:   w_tx_nx = START_LEVEL;
      DATA:    w_tx_nx = w_shift_nx[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_tx_nx = w_par_nx;
`endif
      default: w_tx_nx = IDLE_LEVEL;
    endcase
  end

  // A pop always moves the FSM out of IDLE, so it never clears busy.
  assign w_busy_nx = (w_state_nx != IDLE) || w_push || !w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_baud   <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_tx     <= IDLE_LEVEL;
      r_busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nx;
      r_baud   <= w_baud_nx;
      r_bitcnt <= w_bitcnt_nx;
      r_shift  <= w_shift_nx;
      r_tx     <= w_tx_nx;
      r_busy   <= w_busy_nx;
`ifdef UART_TX_PARITY_EN
      r_par    <= w_par_nx;
`endif
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a serial-line decoder and byte scoreboard.
module tb_uart_tx_fifo;
  localparam int CPB = 4;
  localparam int DEP = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;

  logic       clk = 1'b0, rst = 1'b0, ena = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready, tx, busy;
  logic [2:0] fifo_level;

  int checks = 0, failures = 0;
  int ecyc = 0, ncyc = 0;
  logic [7:0] sb[$];

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEP)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line decoder: samples the second cycle of each bit on the falling edge.
  int         m_cnt = -1;
  int         last_done = -1;
  bit         bb_mode = 1'b0;
  logic [7:0] m_byte, m_exp;
  logic       m_par;
  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      m_cnt = -1;
    end else if (m_cnt < 0) begin
      if (tx === 1'b0) begin
        m_cnt = 0;
        if (bb_mode && last_done >= 0) chk("b2b_gap", ncyc - last_done, 1);
      end
    end else begin
      m_cnt++;
      if (m_cnt >= CPB + 1 && m_cnt <= CPB * 8 + 1 && ((m_cnt - 1) % CPB) == 0)
        m_byte[(m_cnt - CPB - 1) / CPB] = tx;
      if (m_cnt == CPB * 9 + 1) m_par = tx;
      if (m_cnt == CPB * (NB - 1) + 1) chk("stop_bit", tx, 1);
      if (m_cnt == FL - 1) begin
        chk("frame_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          m_exp = sb.pop_front();
          chk("rx_byte", m_byte, m_exp);
`ifdef UART_TX_PARITY_EN
          chk("rx_parity", m_par, ^m_exp);
`endif
        end
        last_done = ncyc;
        m_cnt = -1;
      end
    end
  end

  // Drives one byte onto an idle link and checks tx/busy cycle by cycle.
  task automatic frame_check(input logic [7:0] d);
    logic exp_tx;
    wr_data = d; wr_valid = 1'b1;
    chk("acc_ready", wr_ready, 1);
    sb.push_back(d);
    @(negedge clk);
    wr_valid = 1'b0;
    for (int j = 0; j <= FL + 1; j++) begin
      if (j == 0)                exp_tx = 1'b1;
      else if (j <= CPB)         exp_tx = 1'b0;
      else if (j <= 9 * CPB)     exp_tx = d[(j - CPB - 1) / CPB];
`ifdef UART_TX_PARITY_EN
      else if (j <= 10 * CPB)    exp_tx = ^d;
`endif
      else                       exp_tx = 1'b1;
      chk("tx_seq", tx, exp_tx);
      chk("busy_seq", busy, j <= FL);
      if (j < FL + 1) @(negedge clk);
    end
  endtask

  task automatic wr_three(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    wr_data = a; wr_valid = 1'b1; sb.push_back(a); @(negedge clk);
    wr_data = b; sb.push_back(b); @(negedge clk);
    wr_data = c; sb.push_back(c); @(negedge clk);
    wr_valid = 1'b0;
  endtask

  logic [7:0] fill [6] = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h3C, 8'hC3};
  int e0, w;

  initial begin
    // Reset asserted between clock edges.
    repeat (2) @(negedge clk);
    rst = 1'b1; #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_level", fifo_level, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single byte timing.
    frame_check(8'hA5);
    repeat (2) @(negedge clk);

`ifdef UART_TX_PARITY_EN
    frame_check(8'h07);
    repeat (2) @(negedge clk);
    frame_check(8'h03);
    repeat (2) @(negedge clk);
`endif

    // Fill the FIFO, hold the sixth byte off, expect contiguous frames.
    last_done = -1; bb_mode = 1'b1;
    e0 = ecyc + 1;
    for (int i = 0; i < 5; i++) begin
      wr_data = fill[i]; wr_valid = 1'b1;
      chk("fill_ready", wr_ready, 1);
      sb.push_back(fill[i]);
      @(negedge clk);
    end
    wr_data = fill[5];
    chk("fill_level", fifo_level, 4);
    chk("fill_wr_ready", wr_ready, 0);
    w = 0;
    while (!wr_ready && w < 100) begin @(negedge clk); w++; end
    chk("held_edge", ecyc + 1 - e0, 42);
    sb.push_back(fill[5]);
    @(negedge clk);
    wr_valid = 1'b0;
    w = 0;
    while (busy && w < 400) begin @(negedge clk); w++; end
    chk("burst_end", ecyc - e0, 1 + 6 * FL);
    chk("burst_drained", sb.size(), 0);
    bb_mode = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during bit 3 of 0x55 with two bytes queued.
    wr_three(8'h55, 8'h11, 8'h22);
    repeat (16) @(negedge clk);
    chk("mid_tx_pre", tx, 0);
    chk("mid_level_pre", fifo_level, 2);
    rst = 1'b1; sb.delete(); #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      chk("post_rst_idle", tx, 1);
      @(negedge clk);
    end
    chk("post_rst_busy", busy, 0);

    // Drop ena mid-frame with two bytes queued.
    wr_three(8'h3C, 8'h5A, 8'hC3);
    repeat (8) @(negedge clk);
    ena = 1'b0; #1;
    chk("ena0_ready", wr_ready, 0);
    repeat (35) @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      chk("ena0_tx", tx, 1);
      chk("ena0_level", fifo_level, 2);
      @(negedge clk);
    end
    chk("ena0_busy", busy, 1);
    chk("ena0_sb", sb.size(), 2);
    ena = 1'b1;
    w = 0;
    while (busy && w < 200) begin @(negedge clk); w++; end
    chk("resume_sb", sb.size(), 0);
    chk("resume_level", fifo_level, 0);
    chk("resume_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
